// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, radix-4 Booth multiply,
// non-restoring signed divide, start/busy/done handshake, HI/LO result pair.
module iterative_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned AW = SHW + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NEG  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_SHRA = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DIV_FIX,
        S_FINISH
    } state_e;

    state_e         state;
    logic [CW-1:0]  count;
    logic [W+1:0]   mcand;
    logic [W+1:0]   mul_hi;
    logic [W-1:0]   mul_lo;
    logic           mul_x;
    logic [W+1:0]   div_r;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_d;
    logic           sign_a;
    logic           sign_q;
    logic [W-1:0]   pend_lo;
    logic [W-1:0]   pend_hi;
    logic           pend_dbz;

    logic [SHW-1:0] amt;
    logic [AW-1:0]  ramt;
    logic [W-1:0]   single_lo;
    logic [W-1:0]   single_hi;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic [W+1:0]   addend;
    logic [W+1:0]   mul_sum;
    logic [2*W+2:0] mul_sh;
    logic [W+1:0]   div_sh;
    logic [W+1:0]   div_step;
    logic [W-1:0]   rem_mag;

    // Single-cycle results (also the divide-by-zero response) from live operands
    always_comb begin
        amt       = B[SHW-1:0];
        ramt      = AW'(W) - AW'(amt);
        single_lo = '0;
        single_hi = '0;
        case (op)
            OP_AND:  single_lo = A & B;
            OP_OR:   single_lo = A | B;
            OP_NEG:  single_lo = -A;
            OP_NOT:  single_lo = ~A;
            OP_SHR:  single_lo = A >> amt;
            OP_SHRA: single_lo = $unsigned($signed(A) >>> amt);
            OP_SHL:  single_lo = A << amt;
            OP_ROR:  single_lo = (A >> amt) | (A << ramt);
            OP_ROL:  single_lo = (A << amt) | (A >> ramt);
            OP_ADD:  single_lo = A + B;
            OP_SUB:  single_lo = A - B;
            OP_DIV: begin
                single_lo = '1;
                single_hi = A;
            end
            default: ;
        endcase
    end

    // Operand magnitudes for the unsigned divide core
    always_comb begin
        abs_a = A[W-1] ? -A : A;
        abs_b = B[W-1] ? -B : B;
    end

    // Booth radix-4 step: recode bit pair, accumulate, arithmetic shift by 2
    always_comb begin
        addend = '0;
        case ({mul_lo[1:0], mul_x})
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = -(mcand << 1);
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
        mul_sum = mul_hi + addend;
        mul_sh  = $unsigned($signed({mul_sum, mul_lo, mul_x}) >>> 2);
    end

    // Non-restoring step and final remainder correction
    always_comb begin
        div_sh   = {div_r[W:0], div_q[W-1]};
        div_step = div_r[W+1] ? (div_sh + {2'b00, div_d}) : (div_sh - {2'b00, div_d});
        rem_mag  = div_r[W+1] ? (div_r[W-1:0] + div_d) : div_r[W-1:0];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            count       <= '0;
            mcand       <= '0;
            mul_hi      <= '0;
            mul_lo      <= '0;
            mul_x       <= 1'b0;
            div_r       <= '0;
            div_q       <= '0;
            div_d       <= '0;
            sign_a      <= 1'b0;
            sign_q      <= 1'b0;
            pend_lo     <= '0;
            pend_hi     <= '0;
            pend_dbz    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        pend_dbz    <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand  <= {{2{A[W-1]}}, A};
                            mul_hi <= '0;
                            mul_lo <= B;
                            mul_x  <= 1'b0;
                            count  <= CW'(W / 2);
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else if ((op == OP_DIV) && (B != '0)) begin
                            div_r  <= '0;
                            div_q  <= abs_a;
                            div_d  <= abs_b;
                            sign_a <= A[W-1];
                            sign_q <= A[W-1] ^ B[W-1];
                            count  <= CW'(W);
                            busy   <= 1'b1;
                            state  <= S_DIV;
                        end else begin
                            pend_lo  <= single_lo;
                            pend_hi  <= single_hi;
                            pend_dbz <= (op == OP_DIV);
                            state    <= S_FINISH;
                        end
                    end
                end
                S_MUL: begin
                    mul_hi <= mul_sh[2*W+2:W+1];
                    mul_lo <= mul_sh[W:1];
                    mul_x  <= mul_sh[0];
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        pend_hi <= mul_sh[2*W:W+1];
                        pend_lo <= mul_sh[W:1];
                        busy    <= 1'b0;
                        state   <= S_FINISH;
                    end
                end
                S_DIV: begin
                    div_r <= div_step;
                    div_q <= {div_q[W-2:0], ~div_step[W+1]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    pend_lo <= sign_q ? -div_q : div_q;
                    pend_hi <= sign_a ? -rem_mag : rem_mag;
                    busy    <= 1'b0;
                    state   <= S_FINISH;
                end
                S_FINISH: begin
                    result_lo   <= pend_lo;
                    result_hi   <= pend_hi;
                    div_by_zero <= pend_dbz;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: stimulus pushes expected responses,
// a monitor pops and compares on every done pulse.
module tb_iterative_alu;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NEG  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_SHRA = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_ROL  = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;

    typedef struct {
        string        name;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
        int           nbusy;
        int           start_edge;
    } exp_t;

    logic         clock;
    logic         clear;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    iterative_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic edbz, input int lat, input int nb, input bit push);
        exp_t e;
        e.name       = name;
        e.lo         = elo;
        e.hi         = ehi;
        e.dbz        = edbz;
        e.lat        = lat;
        e.nbusy      = nb;
        e.start_edge = cyc + 1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                       input logic edbz, input int lat, input int nb);
        issue(name, o, x, y, elo, ehi, edbz, lat, nb, 1'b1);
        wait_done(name);
    endtask

    // Monitor: busy cycle count, latency and results checked on each done
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (clear !== 1'b1) begin
                busy_cnt = 0;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=done required=none lo=%h", result_lo);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_lo"}, result_lo, e.lo);
                        chk({e.name, "_hi"}, result_hi, e.hi);
                        chk({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
                        chk({e.name, "_lat"}, W'(cyc - e.start_edge), W'(e.lat));
                        chk({e.name, "_busy"}, W'(busy_cnt), W'(e.nbusy));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_lo", result_lo, '0);
        chk("rst_hi", result_hi, '0);
        chk("rst_dbz", W'(div_by_zero), '0);
        clear = 1'b1;
        tick();

        run("and",  OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'h0, 1'b0, 1, 0);
        run("or",   OP_OR,   32'h0000FF00, 32'h00FF0000, 32'h00FFFF00, 32'h0, 1'b0, 1, 0);
        run("neg",  OP_NEG,  32'h00000005, 32'h0,        32'hFFFFFFFB, 32'h0, 1'b0, 1, 0);
        run("not",  OP_NOT,  32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 32'h0, 1'b0, 1, 0);
        run("ror",  OP_ROR,  32'h00000001, 32'hFFFFFFE1, 32'h80000000, 32'h0, 1'b0, 1, 0);
        run("shra", OP_SHRA, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1, 0);
        run("shr",  OP_SHR,  32'h80000000, 32'h00000024, 32'h08000000, 32'h0, 1'b0, 1, 0);
        run("shl",  OP_SHL,  32'h00000003, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1, 0);
        run("rol",  OP_ROL,  32'h80000001, 32'h00000004, 32'h00000018, 32'h0, 1'b0, 1, 0);
        run("ror0", OP_ROR,  32'h12345678, 32'h00000020, 32'h12345678, 32'h0, 1'b0, 1, 0);
        run("sub",  OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 1, 0);
        run("rsv",  OP_RSV,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0, 1'b0, 1, 0);

        run("mul_m3x7",   OP_MUL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 17, 16);
        run("mul_minmin", OP_MUL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 17, 16);
        run("mul_maxmax", OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b0, 17, 16);
        run("mul_m1m1",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 17, 16);

        run("div_m17_5",  OP_DIV, 32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 34, 33);
        run("div_100_7",  OP_DIV, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34, 33);
        run("div_7_m2",   OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34, 33);
        run("div_m7_m2",  OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 34, 33);
        run("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34, 33);
        run("div_zero",   OP_DIV, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, 0);
        run("add_wrap",   OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1, 0);

        // A start pulse while a multiply is in flight must be ignored
        issue("mul_6x7", OP_MUL, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 17, 16, 1'b1);
        repeat (3) tick();
        start = 1'b1;
        op    = OP_ADD;
        a     = 32'h11111111;
        b     = 32'h22222222;
        tick();
        start = 1'b0;
        wait_done("mul_6x7");

        // Clear mid-divide: outputs drop at once and the divide never completes
        issue("div_abort", OP_DIV, 32'hFFFFFFEF, 32'h00000005, 32'h0, 32'h0, 1'b0, 34, 33, 1'b0);
        repeat (8) tick();
        clear = 1'b0;
        #1;
        chk("clr_busy", W'(busy), '0);
        chk("clr_done", W'(done), '0);
        chk("clr_lo", result_lo, '0);
        chk("clr_hi", result_hi, '0);
        chk("clr_dbz", W'(div_by_zero), '0);
        tick();
        tick();
        clear = 1'b1;
        repeat (40) tick();
        chk("post_clr_busy", W'(busy), '0);
        run("div_1000_m33", OP_DIV, 32'd1000, 32'hFFFFFFDF, 32'hFFFFFFE2, 32'h0000000A, 1'b0, 34, 33);

        repeat (3) tick();
        chk("sb_empty", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, multi-cycle successor to the combinational datapath ALU.
- Single-cycle ops: logic, shift, rotate, add and sub. Multi-cycle ops: radix-4 bit-pair (Booth) signed multiply and non-restoring signed divide.
- Uses a start/busy/done handshake and produces a double-width HI/LO result, so the control unit can load the HI and LO registers directly.
- Sits between the bus-side A/Y register and the Z (HI/LO) register pair.

Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- SHW, $clog2(WIDTH), number of low B bits used as the shift/rotate amount.

Ports:
- clock, input, 1, rising-edge system clock.
- clear, input, 1, asynchronous active-low reset.
- start, input, 1, launches an operation; sampled only in IDLE.
- op, input, 4, operation select; sampled with start.
- A, input, WIDTH, operand A (dividend / multiplicand); sampled with start.
- B, input, WIDTH, operand B (divisor / multiplier / shift amount); sampled with start.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when the results are valid.
- result_lo, output, WIDTH, primary result, product low half, or quotient.
- result_hi, output, WIDTH, product high half, or remainder; 0 for single-cycle ops.
- div_by_zero, output, 1, set with done on a DIV with B == 0; cleared on the next accepted start.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 NEG (two's complement of A), 0011 NOT A.
  - 0100 SHR (logical), 0101 SHRA (arithmetic), 0110 SHL, 0111 ROR, 1000 ROL. Amount is B[SHW-1:0]; B bits above SHW are ignored.
  - 1001 ADD, 1010 SUB (A−B), modulo 2^WIDTH with no carry-out.
  - 1011 MUL (signed × signed, 2·WIDTH-bit product), 1100 DIV (signed).
  - 1101–1111 are reserved: result_lo = result_hi = 0, completed as a single-cycle op.
- Reset (clear low, any time, including mid-operation): state = IDLE, busy = 0, done = 0, result_lo = 0, result_hi = 0, div_by_zero = 0, internal counter and accumulators = 0. No partial result survives.
- States: IDLE, MUL, DIV, DIV_FIX, FINISH.
- IDLE:
  - start = 1 captures op, A and B and clears div_by_zero.
  - Single-cycle op or DIV with B == 0 → FINISH.
  - MUL → MUL, count = WIDTH/2.
  - DIV → DIV, count = WIDTH. Operands are converted to magnitudes; signs are recorded.
- MUL: each cycle, one Booth recode of the multiplier bit pair (+0, ±M, ±2M) into the upper accumulator, then arithmetic shift right by 2. count−1; at 0 → FINISH.
- DIV: each cycle, one non-restoring step (shift the partial remainder left; subtract or add the divisor based on the remainder sign; set the quotient bit). count−1; at 0 → DIV_FIX.
- DIV_FIX: if the partial remainder is negative, add the divisor back. Then apply the signs:
  - quotient negated if the A and B signs differ;
  - remainder takes the sign of A (truncation toward zero). → FINISH.
- FINISH: result registers loaded, done = 1 for this cycle, busy = 0 → IDLE.
- Divide by zero: result_lo = all ones, result_hi = A, div_by_zero = 1.
- busy is high in MUL, DIV and DIV_FIX, and low in IDLE and FINISH.
- Latency from the start edge to the edge asserting done:
  - 1 cycle for single-cycle ops, reserved ops and divide by zero;
  - WIDTH/2 + 1 for MUL;
  - WIDTH + 2 for DIV.
- start while busy or in FINISH is ignored; no queuing.
- start in the IDLE cycle immediately after done is accepted, giving back-to-back throughput.
- result_lo/result_hi hold their values until the next done; they do not change during busy.
- Overflow cases wrap with no flag: MUL of the most-negative × most-negative (correct 2·WIDTH product), DIV of the most-negative by −1 (quotient wraps to most-negative, remainder 0).

Test Plan (WIDTH = 32):
- AND, A = 0xF0F01234, B = 0x0FF0FFFF → done exactly 1 cycle after start, result_lo = 0x00F01234, result_hi = 0, busy never high.
- ROR, A = 0x00000001, B = 0xFFFFFFE1 (amount 1) → result_lo = 0x80000000. SHRA, A = 0x80000000, B = 4 → result_lo = 0xF8000000.
- MUL, A = 0xFFFFFFFD (−3), B = 7 → busy high 16 cycles, done at cycle 17, result_hi = 0xFFFFFFFF, result_lo = 0xFFFFFFEB. Then MUL 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV, A = 0xFFFFFFEF (−17), B = 5 → done at cycle 34, result_lo = 0xFFFFFFFD (−3), result_hi = 0xFFFFFFFE (−2), div_by_zero = 0. Also 100 / 7 → lo = 14, hi = 2.
- DIV, A = 0x12345678, B = 0 → done at cycle 1, div_by_zero = 1, lo = 0xFFFFFFFF, hi = 0x12345678. The next ADD start clears div_by_zero; ADD 0xFFFFFFFF + 1 → lo = 0.
- Start MUL, pulse start with ADD at cycle 5 → ignored, MUL result correct at cycle 17. Start DIV, drive clear low at cycle 10 → outputs 0 immediately, no done. After release, a new DIV completes correctly.
